mem_bist_16x4: RTL and testbench



---
 rtl/mem_bist_16x4.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_bist_16x4.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_16x4.sv
// March C- BIST sequencer for a 16x4 dual-port SRAM wrapper.
// Writes go through port 0 and reads through READ_PORT. The first miscompare is captured.
module mem_bist_16x4 #(
  parameter int READ_PORT = 0,
  parameter int RD_LAT    = 1
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [3:0] FAIL_ADDR,
  output logic [2:0] FAIL_ELEM,
  output logic [3:0] FAIL_BITS,
  output logic [3:0] A0,
  output logic [3:0] D0,
  output logic [3:0] WEM0,
  output logic [3:0] WEM1,
  output logic       WE0,
  output logic       CE0,
  input  logic [3:0] Q0,
  input  logic [3:0] Q1,
  output logic [3:0] A1,
  output logic [3:0] D1,
  output logic       WE1,
  output logic       CE1
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic       v;
    logic       last;
    logic [3:0] exp;
    logic [3:0] addr;
    logic [2:0] elem;
  } cmp_t;

  state_t     state_q, state_d;
  logic [2:0] elem_q, elem_d;
  logic [3:0] addr_q, addr_d;
  logic       phase_q, phase_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       fail_q, fail_d;
  logic [3:0] fail_addr_q, fail_addr_d, fail_bits_q, fail_bits_d;
  logic [2:0] fail_elem_q, fail_elem_d;
  logic [3:0] a0_q, a0_d, a1_q, a1_d, d0_q, d0_d;
  logic       ce0_q, ce0_d, we0_q, we0_d, ce1_q, ce1_d;
  logic       start_ok, two_op;
  logic [3:0] acc_addr, q_rd, miss;
  cmp_t       pipe_q [RD_LAT];
  cmp_t       pipe_in, cmp_s;

  function automatic logic is_rd(input logic [2:0] e, input logic p);
    return (e == 3'd5) || ((e != 3'd0) && !p);
  endfunction

  // E3/E4 walk downward; the counter always counts up and is inverted here.
  function automatic logic [3:0] phys(input logic [2:0] e, input logic [3:0] a);
    return ((e == 3'd3) || (e == 3'd4)) ? ~a : a;
  endfunction

  function automatic logic [3:0] rd_bg(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? 4'hF : 4'h0;
  endfunction

  function automatic logic [3:0] wr_bg(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? 4'hF : 4'h0;
  endfunction

  assign start_ok = START && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign two_op   = (elem_q != 3'd0) && (elem_q != 3'd5);
  assign q_rd     = (READ_PORT == 1) ? Q1 : Q0;
  assign cmp_s    = pipe_q[RD_LAT-1];
  assign miss     = cmp_s.exp ^ q_rd;

  always_comb begin
    pipe_in      = '0;
    pipe_in.v    = (state_q == S_RUN) && is_rd(elem_q, phase_q);
    pipe_in.last = (elem_q == 3'd5) && (addr_q == 4'd15);
    pipe_in.exp  = rd_bg(elem_q);
    pipe_in.addr = phys(elem_q, addr_q);
    pipe_in.elem = elem_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_bits_q <= '0;
      a0_q        <= '0;
      a1_q        <= '0;
      d0_q        <= '0;
      ce0_q       <= 1'b0;
      we0_q       <= 1'b0;
      ce1_q       <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_bits_q <= fail_bits_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
      d0_q        <= d0_d;
      ce0_q       <= ce0_d;
      we0_q       <= we0_d;
      ce1_q       <= ce1_d;
      pipe_q[0]   <= pipe_in;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_RUN;
          elem_d  = '0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      S_RUN: begin
        if (two_op && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          addr_d  = addr_q + 4'd1;
          if (addr_q == 4'd15) begin
            if (elem_q == 3'd5) state_d = S_DRAIN;
            else                elem_d  = elem_q + 3'd1;
          end
        end
      end
      S_DRAIN: begin
        if (cmp_s.v && cmp_s.last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next counter values, so they line up with elem_q/addr_q.
  always_comb begin
    busy_d      = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d      = (state_d == S_DONE);
    ce0_d       = 1'b0;
    we0_d       = 1'b0;
    ce1_d       = 1'b0;
    a0_d        = a0_q;
    a1_d        = a1_q;
    d0_d        = d0_q;
    acc_addr    = phys(elem_d, addr_d);
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_bits_d = fail_bits_q;
    if (state_d == S_RUN) begin
      if (!is_rd(elem_d, phase_d)) begin
        ce0_d = 1'b1;
        we0_d = 1'b1;
        a0_d  = acc_addr;
        d0_d  = wr_bg(elem_d);
      end else if (READ_PORT == 1) begin
        ce1_d = 1'b1;
        a1_d  = acc_addr;
      end else begin
        ce0_d = 1'b1;
        a0_d  = acc_addr;
      end
    end
    if (start_ok) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
      fail_bits_d = '0;
    end else if (cmp_s.v && (miss != 4'h0) && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = cmp_s.addr;
      fail_elem_d = cmp_s.elem;
      fail_bits_d = miss;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign FAIL      = fail_q;
  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_ELEM = fail_elem_q;
  assign FAIL_BITS = fail_bits_q;
  assign A0        = a0_q;
  assign D0        = d0_q;
  assign WE0       = we0_q;
  assign CE0       = ce0_q;
  assign A1        = a1_q;
  assign CE1       = ce1_q;
  assign D1        = 4'h0;
  assign WE1       = 1'b0;
  assign WEM0      = 4'hF;
  assign WEM1      = 4'hF;

endmodule

// File: tb/tb_mem_bist_16x4.sv
// Bench for mem_bist_16x4: both READ_PORT variants run side by side on faulty SRAM models.
// The March C- reference pushes expected accesses/results; a negedge monitor pops and checks.
module tb_mem_bist_16x4;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [3:0] data;
  } acc_t;

  typedef struct packed {
    int         start;
    logic       fail;
    logic [3:0] addr;
    logic [2:0] elem;
    logic [3:0] bits;
  } res_t;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic       busy [2], done [2], fail [2], ce0 [2], we0 [2], ce1 [2], we1 [2];
  logic [3:0] fa [2], fb [2], a0 [2], d0 [2], a1 [2], d1 [2], wem0 [2], wem1 [2];
  logic [2:0] fe [2];
  logic [3:0] sa1 [16];
  logic [3:0] sa0 [16];

  acc_t acc_q0 [$];
  acc_t acc_q1 [$];
  res_t res_q0 [$];
  res_t res_q1 [$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int ce_cnt [2];
  logic [1:0] done_prev = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [3:0] mem [16];
    logic [3:0] q0_r = 4'h0;
    logic [3:0] q1_r = 4'h0;

    mem_bist_16x4 #(.READ_PORT(gi)) u_dut (
      .CLK(clk), .RSTN(rstn), .START(start),
      .BUSY(busy[gi]), .DONE(done[gi]), .FAIL(fail[gi]),
      .FAIL_ADDR(fa[gi]), .FAIL_ELEM(fe[gi]), .FAIL_BITS(fb[gi]),
      .A0(a0[gi]), .D0(d0[gi]), .WEM0(wem0[gi]), .WEM1(wem1[gi]),
      .WE0(we0[gi]), .CE0(ce0[gi]), .Q0(q0_r), .Q1(q1_r),
      .A1(a1[gi]), .D1(d1[gi]), .WE1(we1[gi]), .CE1(ce1[gi])
    );

    // Stuck-at faults are applied on the read path of both ports.
    always @(posedge clk) begin
      if (ce0[gi] && we0[gi]) mem[a0[gi]] <= d0[gi];
      if (ce0[gi] && !we0[gi]) q0_r <= (mem[a0[gi]] | sa1[a0[gi]]) & ~sa0[a0[gi]];
      if (ce1[gi] && !we1[gi]) q1_r <= (mem[a1[gi]] | sa1[a1[gi]]) & ~sa0[a1[gi]];
    end
  end

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d act=%0h exp=%0h t=%0t", name, d, act, exp, $time);
  endtask

  // Reference: walk March C- over an ideal array with the fault masks applied on reads.
  task automatic push_test();
    logic [3:0] m [16];
    res_t r;
    acc_t e;
    logic [3:0] a, ex, obs;
    r = '0;
    r.start = cyc;
    for (int i = 0; i < 16; i++) m[i] = 4'h0;
    for (int el = 0; el < 6; el++) begin
      for (int i = 0; i < 16; i++) begin
        a = (el == 3 || el == 4) ? 4'(15 - i) : 4'(i);
        if (el != 0) begin
          ex  = (el == 2 || el == 4) ? 4'hF : 4'h0;
          obs = (m[a] | sa1[a]) & ~sa0[a];
          if (obs != ex && !r.fail) begin
            r.fail = 1'b1;
            r.addr = a;
            r.elem = 3'(el);
            r.bits = obs ^ ex;
          end
          e = '{rd: 1'b1, addr: a, data: ex};
          acc_q0.push_back(e);
          acc_q1.push_back(e);
        end
        if (el != 5) begin
          m[a] = (el == 1 || el == 3) ? 4'hF : 4'h0;
          e = '{rd: 1'b0, addr: a, data: m[a]};
          acc_q0.push_back(e);
          acc_q1.push_back(e);
        end
      end
    end
    res_q0.push_back(r);
    res_q1.push_back(r);
    ce_cnt[0] = 0;
    ce_cnt[1] = 0;
  endtask

  task automatic mon(input int d);
    acc_t e;
    res_t r;
    int sz, rsz;
    logic [3:0] exp_ctl, act_a, act_d, exp_d;
    sz  = (d == 0) ? acc_q0.size() : acc_q1.size();
    rsz = (d == 0) ? res_q0.size() : res_q1.size();
    if (rsz > 0) begin
      r = (d == 0) ? res_q0[0] : res_q1[0];
      if (cyc - r.start == 1) begin
        chk("busy_cycle1", d, 32'(busy[d]), 32'd1);
        chk("done_cycle1", d, 32'(done[d]), 32'd0);
      end
    end
    if (ce0[d] || ce1[d] || we0[d] || we1[d]) begin
      ce_cnt[d]++;
      if (sz == 0) begin
        chk("access_extra", d, 32'({ce0[d], we0[d], ce1[d]}), 32'd0);
      end else begin
        e = (d == 0) ? acc_q0.pop_front() : acc_q1.pop_front();
        exp_ctl = !e.rd ? 4'b1100 : (d == 0) ? 4'b1000 : 4'b0010;
        act_a   = (e.rd && d == 1) ? a1[d] : a0[d];
        act_d   = e.rd ? 4'h0 : d0[d];
        exp_d   = e.rd ? 4'h0 : e.data;
        chk("access", d, {20'd0, ce0[d], we0[d], ce1[d], we1[d], act_a, act_d},
            {20'd0, exp_ctl, e.addr, exp_d});
      end
    end
    if (done[d] && !done_prev[d]) begin
      if (rsz == 0) begin
        chk("done_extra", d, 32'(done[d]), 32'd0);
      end else begin
        r = (d == 0) ? res_q0.pop_front() : res_q1.pop_front();
        sz = (d == 0) ? acc_q0.size() : acc_q1.size();
        chk("done_cycle", d, cyc - r.start, 32'd162);
        chk("busy_at_done", d, 32'(busy[d]), 32'd0);
        chk("fail_flag", d, 32'(fail[d]), 32'(r.fail));
        chk("fail_addr", d, 32'(fa[d]), 32'(r.addr));
        chk("fail_elem", d, 32'(fe[d]), 32'(r.elem));
        chk("fail_bits", d, 32'(fb[d]), 32'(r.bits));
        chk("ce_cycles", d, ce_cnt[d], 32'd160);
        chk("accesses_left", d, sz, 32'd0);
        $display("dut%0d test done: cycle=%0d fail=%0d addr=%0d elem=%0d bits=%b",
                 d, cyc - r.start, fail[d], fa[d], fe[d], fb[d]);
      end
    end
    done_prev[d] = done[d];
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      mon(0);
      mon(1);
    end
  end

  task automatic reset_check();
    for (int d = 0; d < 2; d++) begin
      chk("reset_outputs", d,
          {2'd0, busy[d], done[d], fail[d], fa[d], fe[d], fb[d], a0[d], d0[d], a1[d],
           ce0[d], we0[d], ce1[d], we1[d]}, 32'd0);
      chk("const_ports", d, {19'd0, wem0[d], wem1[d], d1[d], we1[d]}, 32'h1FE0);
    end
  endtask

  task automatic set_fault(input int a, input int b, input int pol);
    for (int i = 0; i < 16; i++) begin
      sa1[i] = 4'h0;
      sa0[i] = 4'h0;
    end
    if (a >= 0) begin
      if (pol != 0) sa1[a][b] = 1'b1;
      else          sa0[a][b] = 1'b1;
    end
  endtask

  task automatic run_test(input string tag, input int rst_at, input bit repulse);
    $display("run %s", tag);
    @(negedge clk);
    push_test();
    start = 1'b1;
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      start = repulse && (k == 80);
      if (rst_at != 0 && k == rst_at) begin
        rstn = 1'b0;
        #1;
        reset_check();
        acc_q0.delete();
        acc_q1.delete();
        res_q0.delete();
        res_q1.delete();
        done_prev = 2'b00;
        @(negedge clk);
        rstn = 1'b1;
        break;
      end
      if (res_q0.size() == 0 && res_q1.size() == 0) break;
    end
    start = 1'b0;
    if (rst_at == 0) chk("timeout", 0, res_q0.size() + res_q1.size(), 32'd0);
  endtask

  initial begin
    set_fault(-1, 0, 0);
    repeat (3) @(negedge clk);
    reset_check();
    rstn = 1'b1;
    @(negedge clk);
    run_test("fault_free", 0, 1'b0);
    set_fault(5, 2, 1);
    run_test("sa1_addr5_bit2", 0, 1'b0);
    set_fault(10, 0, 0);
    run_test("sa0_addr10_bit0", 0, 1'b0);
    set_fault(-1, 0, 0);
    run_test("reset_at_50", 50, 1'b0);
    run_test("after_reset", 0, 1'b0);
    run_test("start_while_busy", 0, 1'b1);
    for (int t = 0; t < 4; t++) begin
      set_fault(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      run_test("random_fault", 0, 1'b0);
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
